screen_scaler: RTL and testbench
================================

// Module: screen_scaler
// PURPOSE
//  Parametrised VGA timing generator and integer pixel-to-cell scaler.
//  Produces sync and blanking, and maps each displayed pixel to a logical
//  framebuffer cell (x, y). Supports a centred or offset letterbox window
//  inside the active area, and configurable sync polarity.
//  Sits between the display memory read port and the VGA pins. Supersedes
//  the fixed 64x32-on-640x480 screen driver.
// PARAMETERS
//  H_ACTIVE  640  active pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  active lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
//  HS_POL    0    hs active level (0 = active-low)
//  VS_POL    0    vs active level (0 = active-low)
//  X_MAX     64   logical cells per row
//  Y_MAX     32   logical cell rows
//  X_SCALE   10   pixels per cell, horizontally (>=1)
//  Y_SCALE   15   lines per cell, vertically (>=1)
//  X_OFFSET  0    first window pixel inside the active line
//  Y_OFFSET  0    first window line inside the active frame
// PORTS
//  clk          in   1                  pixel clock
//  rst          in   1                  synchronous reset, active-high
//  x            out  $clog2(X_MAX)      cell column; 0 outside the window
//  y            out  $clog2(Y_MAX)      cell row; 0 outside the window
//  in_window    out  1                  current pixel lies in the scaled window
//  hs           out  1                  horizontal sync, level set by HS_POL
//  hs_valid     out  1                  horizontal active region
//  vs           out  1                  vertical sync, level set by VS_POL
//  vs_valid     out  1                  vertical active region
//  frame_start  out  1                  1-cycle pulse at pixel (0,0)
// BEHAVIOUR
//  - Derived totals:
//    - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP
//    - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP
//  - Elaboration-time error if X_OFFSET + X_MAX*X_SCALE > H_ACTIVE,
//    or if Y_OFFSET + Y_MAX*Y_SCALE > V_ACTIVE.
//  - Horizontal counter h counts 0..H_TOTAL-1, then wraps to 0.
//    Vertical counter v increments on the h wrap and wraps at V_TOTAL-1.
//  - hs_valid = (h < H_ACTIVE). vs_valid = (v < V_ACTIVE).
//  - hs is at its active level for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//    vs is at its active level for v in the equivalent vertical window.
//  - Window:
//    - hwin: h in [X_OFFSET, X_OFFSET + X_MAX*X_SCALE)
//    - vwin: v in [Y_OFFSET, Y_OFFSET + Y_MAX*Y_SCALE)
//    - in_window = hwin & vwin
//  - x_div counts 0..X_SCALE-1 while hwin & vwin hold, and is 0 otherwise.
//    When x_div wraps, x increments. x returns to 0 at the end of hwin.
//  - y_div advances once per line, on the last hwin pixel of each vwin line.
//    When y_div wraps, y increments. y and y_div return to 0 at frame end.
//  - x and y never exceed X_MAX-1 and Y_MAX-1. Cell increments never carry
//    into an extra cell.
//  - Latency: every output is registered. The outputs for position (h,v)
//    appear one clk after the counters hold (h,v).
//  - Reset while rst = 1:
//    - h, v, both div counters, x and y are cleared to 0.
//    - hs = ~HS_POL, vs = ~VS_POL.
//    - hs_valid, vs_valid, in_window and frame_start are 0; x = y = 0.
//  - After rst falls:
//    - first cycle: counters are at (0,0) and outputs still hold reset values
//    - second cycle: outputs reflect (0,0), and frame_start = 1
//  - A mid-frame rst aborts the frame immediately. There is no partial-frame
//    recovery; the next frame always restarts at (0,0).
// TESTING
//  T1 defaults: hs low for h 656..751, vs low for v 490..491, 800x525 totals.
//  T2 defaults: x steps every 10 clk, line 0 reads x=0..63,
//     pixel 639 -> x=63 and in_window=1, pixel 640 -> in_window=0 and x=0.
//  T3 defaults: y increments every 15 lines, line 479 -> y=31,
//     line 480 -> vs_valid=0, next frame line 0 -> y=0.
//  T4 X_SCALE=8, X_OFFSET=64, Y_SCALE=8, Y_OFFSET=112:
//     pixel (63,112) -> in_window=0; pixel (64,112) -> x=0, y=0;
//     pixel (575,367) -> x=63, y=31; pixel 576 -> in_window=0.
//  T5 HS_POL=1, VS_POL=1: hs and vs are inverted relative to T1,
//     and idle low during rst.
//  T6 assert rst at h=300, v=200 for 3 clk: outputs take reset values;
//     frame_start pulses 2 clk after release; next line 0 reads x=0, y=0.

Source files
------------

// File: rtl/screen_scaler.sv
// screen_scaler: VGA timing generator with an integer pixel-to-cell scaler.
// A free-running (h, v) raster counter drives sync/blanking. A letterbox
// window inside the active area is divided into X_MAX x Y_MAX cells of
// X_SCALE x Y_SCALE pixels. All outputs are registered, so the outputs
// for raster position (h, v) appear one clock after the counters hold it.
// X_MAX and Y_MAX must be at least 2 so that x and y have a nonzero width.
module screen_scaler #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int X_MAX    = 64,
   parameter int Y_MAX    = 32,
   parameter int X_SCALE  = 10,
   parameter int Y_SCALE  = 15,
   parameter int X_OFFSET = 0,
   parameter int Y_OFFSET = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [$clog2(X_MAX)-1:0]   x,
   output logic [$clog2(Y_MAX)-1:0]   y,
   output logic                       in_window,
   output logic                       hs,
   output logic                       hs_valid,
   output logic                       vs,
   output logic                       vs_valid,
   output logic                       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int XW      = $clog2(X_MAX);
   localparam int YW      = $clog2(Y_MAX);
   localparam int XDW     = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
   localparam int YDW     = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
   localparam int X_SPAN  = X_MAX * X_SCALE;
   localparam int Y_SPAN  = Y_MAX * Y_SCALE;

   localparam logic [HW-1:0]  H_LAST_C      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]  H_ACT_C       = HW'(H_ACTIVE);
   localparam logic [HW-1:0]  HS_BEG_C      = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]  HS_LEN_C      = HW'(H_SYNC);
   localparam logic [HW-1:0]  X_OFF_C       = HW'(X_OFFSET);
   localparam logic [HW-1:0]  X_SPAN_C      = HW'(X_SPAN);
   localparam logic [HW-1:0]  X_LAST_C      = HW'(X_OFFSET + X_SPAN - 1);
   localparam logic [VW-1:0]  V_LAST_C      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]  V_ACT_C       = VW'(V_ACTIVE);
   localparam logic [VW-1:0]  VS_BEG_C      = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]  VS_LEN_C      = VW'(V_SYNC);
   localparam logic [VW-1:0]  Y_OFF_C       = VW'(Y_OFFSET);
   localparam logic [VW-1:0]  Y_SPAN_C      = VW'(Y_SPAN);
   localparam logic [XDW-1:0] X_DIV_LAST_C  = XDW'(X_SCALE - 1);
   localparam logic [YDW-1:0] Y_DIV_LAST_C  = YDW'(Y_SCALE - 1);
   localparam logic [XW-1:0]  X_CELL_LAST_C = XW'(X_MAX - 1);
   localparam logic [YW-1:0]  Y_CELL_LAST_C = YW'(Y_MAX - 1);
   localparam logic           HS_ON_C       = 1'(HS_POL);
   localparam logic           VS_ON_C       = 1'(VS_POL);

   // Reject windows that do not fit inside the active area at elaboration.
   if ((X_OFFSET + X_SPAN) > H_ACTIVE) begin : g_bad_x_window
      $error("screen_scaler: X_OFFSET + X_MAX*X_SCALE exceeds H_ACTIVE");
   end
   if ((Y_OFFSET + Y_SPAN) > V_ACTIVE) begin : g_bad_y_window
      $error("screen_scaler: Y_OFFSET + Y_MAX*Y_SCALE exceeds V_ACTIVE");
   end

   logic [HW-1:0]  h_r, h_nxt_s;
   logic [VW-1:0]  v_r, v_nxt_s;
   logic [XDW-1:0] x_div_r, x_div_nxt_s;
   logic [YDW-1:0] y_div_r, y_div_nxt_s;
   logic [XW-1:0]  x_cell_r, x_cell_nxt_s;
   logic [YW-1:0]  y_cell_r, y_cell_nxt_s;

   logic [HW-1:0]  h_xrel_s, h_srel_s;
   logic [VW-1:0]  v_yrel_s, v_srel_s;
   logic           hwin_s, vwin_s, win_s, h_win_last_s, frame_end_s;
   logic           hs_act_s, vs_act_s;

   logic [XW-1:0]  x_r;
   logic [YW-1:0]  y_r;
   logic           in_window_r, hs_r, hs_valid_r, vs_r, vs_valid_r, frame_start_r;

   // Range tests are done as unsigned (pos - start) < length: a position
   // before the start wraps to a large value and falls outside the range.
   always_comb begin
      h_xrel_s     = h_r - X_OFF_C;
      h_srel_s     = h_r - HS_BEG_C;
      v_yrel_s     = v_r - Y_OFF_C;
      v_srel_s     = v_r - VS_BEG_C;
      hwin_s       = (h_xrel_s < X_SPAN_C);
      vwin_s       = (v_yrel_s < Y_SPAN_C);
      win_s        = hwin_s & vwin_s;
      h_win_last_s = (h_r == X_LAST_C);
      frame_end_s  = (h_r == H_LAST_C) && (v_r == V_LAST_C);
      hs_act_s     = (h_srel_s < HS_LEN_C);
      vs_act_s     = (v_srel_s < VS_LEN_C);
   end

   // Next raster position: h wraps at the end of the line, v steps on that wrap.
   always_comb begin
      v_nxt_s = v_r;
      if (h_r == H_LAST_C) begin
         h_nxt_s = {HW{1'b0}};
         if (v_r == V_LAST_C) begin
            v_nxt_s = {VW{1'b0}};
         end else begin
            v_nxt_s = v_r + VW'(1'b1);
         end
      end else begin
         h_nxt_s = h_r + HW'(1'b1);
      end
   end

   // Horizontal cell tracking: divide window pixels by X_SCALE, clear outside
   // the window and on the last window pixel so each line restarts at cell 0.
   always_comb begin
      x_div_nxt_s  = {XDW{1'b0}};
      x_cell_nxt_s = {XW{1'b0}};
      if (win_s && !h_win_last_s) begin
         if (x_div_r == X_DIV_LAST_C) begin
            x_div_nxt_s = {XDW{1'b0}};
            if (x_cell_r == X_CELL_LAST_C) begin
               x_cell_nxt_s = x_cell_r;
            end else begin
               x_cell_nxt_s = x_cell_r + XW'(1'b1);
            end
         end else begin
            x_div_nxt_s  = x_div_r + XDW'(1'b1);
            x_cell_nxt_s = x_cell_r;
         end
      end else begin
         x_div_nxt_s  = {XDW{1'b0}};
         x_cell_nxt_s = {XW{1'b0}};
      end
   end

   // Vertical cell tracking: one step per window line, taken on the last
   // window pixel; the final window line wraps the row back to 0.
   always_comb begin
      y_div_nxt_s  = y_div_r;
      y_cell_nxt_s = y_cell_r;
      if (frame_end_s) begin
         y_div_nxt_s  = {YDW{1'b0}};
         y_cell_nxt_s = {YW{1'b0}};
      end else if (vwin_s && h_win_last_s) begin
         if (y_div_r == Y_DIV_LAST_C) begin
            y_div_nxt_s = {YDW{1'b0}};
            if (y_cell_r == Y_CELL_LAST_C) begin
               y_cell_nxt_s = {YW{1'b0}};
            end else begin
               y_cell_nxt_s = y_cell_r + YW'(1'b1);
            end
         end else begin
            y_div_nxt_s  = y_div_r + YDW'(1'b1);
            y_cell_nxt_s = y_cell_r;
         end
      end else begin
         y_div_nxt_s  = y_div_r;
         y_cell_nxt_s = y_cell_r;
      end
   end

   // Raster and cell state registers; reset restarts the frame at (0,0).
   always_ff @(posedge clk) begin
      if (rst) begin
         h_r      <= {HW{1'b0}};
         v_r      <= {VW{1'b0}};
         x_div_r  <= {XDW{1'b0}};
         y_div_r  <= {YDW{1'b0}};
         x_cell_r <= {XW{1'b0}};
         y_cell_r <= {YW{1'b0}};
      end else begin
         h_r      <= h_nxt_s;
         v_r      <= v_nxt_s;
         x_div_r  <= x_div_nxt_s;
         y_div_r  <= y_div_nxt_s;
         x_cell_r <= x_cell_nxt_s;
         y_cell_r <= y_cell_nxt_s;
      end
   end

   // Output registers: decode the current position one clock behind the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r           <= {XW{1'b0}};
         y_r           <= {YW{1'b0}};
         in_window_r   <= 1'b0;
         hs_r          <= ~HS_ON_C;
         hs_valid_r    <= 1'b0;
         vs_r          <= ~VS_ON_C;
         vs_valid_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         x_r           <= win_s ? x_cell_r : {XW{1'b0}};
         y_r           <= win_s ? y_cell_r : {YW{1'b0}};
         in_window_r   <= win_s;
         hs_r          <= hs_act_s ? HS_ON_C : ~HS_ON_C;
         hs_valid_r    <= (h_r < H_ACT_C);
         vs_r          <= vs_act_s ? VS_ON_C : ~VS_ON_C;
         vs_valid_r    <= (v_r < V_ACT_C);
         frame_start_r <= (h_r == {HW{1'b0}}) && (v_r == {VW{1'b0}});
      end
   end

   assign x           = x_r;
   assign y           = y_r;
   assign in_window   = in_window_r;
   assign hs          = hs_r;
   assign hs_valid    = hs_valid_r;
   assign vs          = vs_r;
   assign vs_valid    = vs_valid_r;
   assign frame_start = frame_start_r;

endmodule

// File: tb/tb_screen_scaler.sv
// Testbench for screen_scaler: four instances (default timing plus three
// reduced-size rasters: plain, offset letterbox, inverted sync polarity)
// share clk and rst and are compared against an arithmetic raster model.
module tb_screen_scaler;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic win, hs, hv, vs, vv, fs;
   } exp_t;

   typedef struct packed {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, xmax, ymax, xs, ys, xo, yo;
   } cfg_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pos = -1;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   logic [5:0] d0_x; logic [4:0] d0_y; logic d0_win, d0_hs, d0_hv, d0_vs, d0_vv, d0_fs;
   logic [2:0] d1_x; logic [1:0] d1_y; logic d1_win, d1_hs, d1_hv, d1_vs, d1_vv, d1_fs;
   logic [2:0] d2_x; logic [1:0] d2_y; logic d2_win, d2_hs, d2_hv, d2_vs, d2_vv, d2_fs;
   logic [2:0] d3_x; logic [1:0] d3_y; logic d3_win, d3_hs, d3_hv, d3_vs, d3_vv, d3_fs;

   screen_scaler dut_def (
      .clk(clk), .rst(rst), .x(d0_x), .y(d0_y), .in_window(d0_win), .hs(d0_hs),
      .hs_valid(d0_hv), .vs(d0_vs), .vs_valid(d0_vv), .frame_start(d0_fs));

   screen_scaler #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2),
      .V_SYNC(2), .V_BP(3), .X_MAX(8), .Y_MAX(4), .X_SCALE(8), .Y_SCALE(12)) dut_small (
      .clk(clk), .rst(rst), .x(d1_x), .y(d1_y), .in_window(d1_win), .hs(d1_hs),
      .hs_valid(d1_hv), .vs(d1_vs), .vs_valid(d1_vv), .frame_start(d1_fs));

   screen_scaler #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2),
      .V_SYNC(2), .V_BP(3), .X_MAX(8), .Y_MAX(4), .X_SCALE(4), .Y_SCALE(5),
      .X_OFFSET(16), .Y_OFFSET(13)) dut_off (
      .clk(clk), .rst(rst), .x(d2_x), .y(d2_y), .in_window(d2_win), .hs(d2_hs),
      .hs_valid(d2_hv), .vs(d2_vs), .vs_valid(d2_vv), .frame_start(d2_fs));

   screen_scaler #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2),
      .V_SYNC(2), .V_BP(3), .HS_POL(1), .VS_POL(1), .X_MAX(8), .Y_MAX(4), .X_SCALE(8),
      .Y_SCALE(12)) dut_pol (
      .clk(clk), .rst(rst), .x(d3_x), .y(d3_y), .in_window(d3_win), .hs(d3_hs),
      .hs_valid(d3_hv), .vs(d3_vs), .vs_valid(d3_vv), .frame_start(d3_fs));

   exp_t obs_a [4];
   assign obs_a[0] = {8'(d0_x), 8'(d0_y), d0_win, d0_hs, d0_hv, d0_vs, d0_vv, d0_fs};
   assign obs_a[1] = {8'(d1_x), 8'(d1_y), d1_win, d1_hs, d1_hv, d1_vs, d1_vv, d1_fs};
   assign obs_a[2] = {8'(d2_x), 8'(d2_y), d2_win, d2_hs, d2_hv, d2_vs, d2_vv, d2_fs};
   assign obs_a[3] = {8'(d3_x), 8'(d3_y), d3_win, d3_hs, d3_hv, d3_vs, d3_vv, d3_fs};

   function automatic cfg_t cfg_of(int d);
      cfg_t c;
      case (d)
         0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 64, 32, 10, 15, 0, 0};
         1:       c = '{64, 4, 8, 4, 48, 2, 2, 3, 0, 0, 8, 4, 8, 12, 0, 0};
         2:       c = '{64, 4, 8, 4, 48, 2, 2, 3, 0, 0, 8, 4, 4, 5, 16, 13};
         default: c = '{64, 4, 8, 4, 48, 2, 2, 3, 1, 1, 8, 4, 8, 12, 0, 0};
      endcase
      return c;
   endfunction

   function automatic string nm(int d);
      case (d)
         0:       return "def";
         1:       return "small";
         2:       return "offset";
         default: return "pol";
      endcase
   endfunction

   // Reference: outputs for the pos-th pixel since reset release (pos < 0: reset).
   function automatic exp_t model(cfg_t c, int p_in);
      exp_t e;
      int   ht, vt, p, h, v;
      bit   hw, vw;
      e = '0;
      e.hs = (c.hpol != 0) ? 1'b0 : 1'b1;
      e.vs = (c.vpol != 0) ? 1'b0 : 1'b1;
      if (p_in < 0) return e;
      ht = c.ha + c.hfp + c.hsw + c.hbp;
      vt = c.va + c.vfp + c.vsw + c.vbp;
      p  = p_in % (ht * vt);
      h  = p % ht;
      v  = p / ht;
      hw = (h >= c.xo) && (h < c.xo + c.xmax * c.xs);
      vw = (v >= c.yo) && (v < c.yo + c.ymax * c.ys);
      e.win = hw && vw;
      if (e.win) begin
         e.x = 8'((h - c.xo) / c.xs);
         e.y = 8'((v - c.yo) / c.ys);
      end
      if ((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw)) e.hs = ~e.hs;
      if ((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw)) e.vs = ~e.vs;
      e.hv = (h < c.ha);
      e.vv = (v < c.va);
      e.fs = (p == 0);
      return e;
   endfunction

   // Advance to the next falling edge; pos tracks the pixel the outputs show.
   task automatic tick();
      @(negedge clk);
      if (rst) pos = -1;
      else     pos = pos + 1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      repeat (3) tick();
      for (int d = 0; d < 4; d++) begin
         e = model(cfg_of(d), -1);
         n_tests++;
         if (obs_a[d] !== e) begin
            n_fail++;
            $display("FAIL reset[%s] got=%h exp=%h", nm(d), obs_a[d], e);
         end
      end
      rst = 1'b0;
      for (int d = 0; d < 4; d++) begin
         e = model(cfg_of(d), -1);
         n_tests++;
         if (obs_a[d] !== e) begin
            n_fail++;
            $display("FAIL reset_hold[%s] got=%h exp=%h", nm(d), obs_a[d], e);
         end
      end
      tick();
      for (int d = 0; d < 4; d++) begin
         e = model(cfg_of(d), pos);
         n_tests++;
         if (obs_a[d] !== e) begin
            n_fail++;
            $display("FAIL first_pixel[%s] got=%h exp=%h", nm(d), obs_a[d], e);
         end
      end
      n_tests++;
      if (obs_a[0].fs !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_start_first got=%b exp=1", obs_a[0].fs);
      end
   endtask

   // Two full small frames back to back, every output of every instance.
   task automatic test_back_to_back();
      exp_t e;
      repeat (2 * 4400 + 60) begin
         tick();
         for (int d = 0; d < 4; d++) begin
            e = model(cfg_of(d), pos);
            n_tests++;
            if (obs_a[d] !== e) begin
               n_fail++;
               $display("FAIL frames[%s] pos=%0d got=%h exp=%h", nm(d), pos, obs_a[d], e);
            end
         end
      end
   endtask

   // Hand-computed boundary points for sync, window edges and cell steps.
   task automatic test_boundaries();
      logic [23:0] got, want;
      string       tag;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      while (pos < 4160) begin
         tick();
         tag  = "";
         got  = 24'd0;
         want = 24'd0;
         case (pos)
            9:    begin tag = "def_x_9";     got = 24'(obs_a[0].x); want = 24'd0; end
            10:   begin tag = "def_x_10";    got = 24'(obs_a[0].x); want = 24'd1; end
            639:  begin tag = "def_px639";   got = {obs_a[0].x, 15'd0, obs_a[0].win}; want = {8'd63, 15'd0, 1'b1}; end
            640:  begin tag = "def_px640";   got = {obs_a[0].x, 15'd0, obs_a[0].win}; want = 24'd0; end
            655:  begin tag = "def_hs_655";  got = 24'(obs_a[0].hs); want = 24'd1; end
            656:  begin tag = "def_hs_656";  got = 24'(obs_a[0].hs); want = 24'd0; end
            751:  begin tag = "def_hs_751";  got = 24'(obs_a[0].hs); want = 24'd0; end
            752:  begin tag = "def_hs_752";  got = 24'(obs_a[0].hs); want = 24'd1; end
            67:   begin tag = "hs_pol_67";   got = {22'd0, obs_a[1].hs, obs_a[3].hs}; want = 24'd2; end
            68:   begin tag = "hs_pol_68";   got = {22'd0, obs_a[1].hs, obs_a[3].hs}; want = 24'd1; end
            75:   begin tag = "hs_pol_75";   got = {22'd0, obs_a[1].hs, obs_a[3].hs}; want = 24'd1; end
            76:   begin tag = "hs_pol_76";   got = {22'd0, obs_a[1].hs, obs_a[3].hs}; want = 24'd2; end
            960:  begin tag = "small_y_v12"; got = {obs_a[1].x, obs_a[1].y, 8'd0}; want = {8'd0, 8'd1, 8'd0}; end
            3765: begin tag = "small_y_v47"; got = {obs_a[1].x, obs_a[1].y, 8'd0}; want = {8'd0, 8'd3, 8'd0}; end
            3840: begin tag = "small_v48";   got = {22'd0, obs_a[1].vv, obs_a[1].win}; want = 24'd0; end
            3999: begin tag = "vs_pol_v49";  got = {22'd0, obs_a[1].vs, obs_a[3].vs}; want = 24'd2; end
            4000: begin tag = "vs_pol_v50";  got = {22'd0, obs_a[1].vs, obs_a[3].vs}; want = 24'd1; end
            4159: begin tag = "vs_pol_v51";  got = {22'd0, obs_a[1].vs, obs_a[3].vs}; want = 24'd1; end
            4160: begin tag = "vs_pol_v52";  got = {22'd0, obs_a[1].vs, obs_a[3].vs}; want = 24'd2; end
            1055: begin tag = "off_15_13";   got = {obs_a[2].x, obs_a[2].y, 7'd0, obs_a[2].win}; want = 24'd0; end
            1056: begin tag = "off_16_13";   got = {obs_a[2].x, obs_a[2].y, 7'd0, obs_a[2].win}; want = 24'd1; end
            2607: begin tag = "off_47_32";   got = {obs_a[2].x, obs_a[2].y, 7'd0, obs_a[2].win}; want = {8'd7, 8'd3, 8'd1}; end
            2608: begin tag = "off_48_32";   got = {obs_a[2].x, obs_a[2].y, 7'd0, obs_a[2].win}; want = 24'd0; end
            default: tag = "";
         endcase
         if (tag != "") begin
            n_tests++;
            if (got !== want) begin
               n_fail++;
               $display("FAIL %s got=%h exp=%h", tag, got, want);
            end
         end
      end
   endtask

   // Reset at small-raster (h=30, v=20) for 3 clocks, then restart at (0,0).
   task automatic test_midframe_reset();
      exp_t e;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      while (pos < 20 * 80 + 30) tick();
      rst = 1'b1;
      repeat (3) begin
         tick();
         for (int d = 0; d < 4; d++) begin
            e = model(cfg_of(d), -1);
            n_tests++;
            if (obs_a[d] !== e) begin
               n_fail++;
               $display("FAIL midreset[%s] got=%h exp=%h", nm(d), obs_a[d], e);
            end
         end
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if ({obs_a[1].fs, obs_a[1].win, obs_a[1].x, obs_a[1].y} !== {1'b1, 1'b1, 8'd0, 8'd0}) begin
         n_fail++;
         $display("FAIL midreset_restart got fs=%b win=%b x=%0d y=%0d exp fs=1 win=1 x=0 y=0",
                  obs_a[1].fs, obs_a[1].win, obs_a[1].x, obs_a[1].y);
      end
      repeat (100) begin
         tick();
         for (int d = 0; d < 4; d++) begin
            e = model(cfg_of(d), pos);
            n_tests++;
            if (obs_a[d] !== e) begin
               n_fail++;
               $display("FAIL midreset_line0[%s] pos=%0d got=%h exp=%h", nm(d), pos, obs_a[d], e);
            end
         end
      end
   endtask

   // Random run lengths interrupted by random-length resets.
   task automatic test_random_reset();
      exp_t e;
      int   n;
      for (int it = 0; it < 6; it++) begin
         n = int'($urandom_range(1, 3000));
         repeat (n) begin
            tick();
            for (int d = 0; d < 4; d++) begin
               e = model(cfg_of(d), pos);
               n_tests++;
               if (obs_a[d] !== e) begin
                  n_fail++;
                  $display("FAIL random[%s] it=%0d pos=%0d got=%h exp=%h", nm(d), it, pos, obs_a[d], e);
               end
            end
         end
         rst = 1'b1;
         n = int'($urandom_range(1, 4));
         repeat (n) begin
            tick();
            for (int d = 0; d < 4; d++) begin
               e = model(cfg_of(d), pos);
               n_tests++;
               if (obs_a[d] !== e) begin
                  n_fail++;
                  $display("FAIL random_rst[%s] it=%0d got=%h exp=%h", nm(d), it, obs_a[d], e);
               end
            end
         end
         rst = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_boundaries();
      test_midframe_reset();
      test_random_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
